// File: rtl/uart_defs.sv
// Shared UART constants and receiver/transmitter FSM state encoding.
package uart_defs;

  localparam int unsigned CLK_FREQ     = 50_000_000;
  localparam int unsigned BAUD         = 115_200;
  localparam int unsigned CLKS_PER_BIT = CLK_FREQ / BAUD;
  localparam int unsigned TIMEOUT_BITS = 20;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    START = 2'd1,
    DATA  = 2'd2,
    STOP  = 2'd3
  } rx_state_e;

endpackage

// File: rtl/uart_rx_byte.sv
// 8N1 byte receiver: rx synchronizer, bit-timing counter and frame FSM.
// byte_ok/stop_err are decoded in the stop-sample cycle and registered by the parent.
module uart_rx_byte #(
  parameter int unsigned BIT_CLKS = uart_defs::CLKS_PER_BIT
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       rx,
  output logic [7:0] byte_out,
  output logic       byte_ok,
  output logic       stop_err,
  output logic       idle_c
);
  import uart_defs::*;

  localparam int unsigned CNT_W = $clog2(BIT_CLKS);
  localparam logic [CNT_W-1:0] HALF_LAST = CNT_W'(BIT_CLKS / 2 - 1);
  localparam logic [CNT_W-1:0] BIT_LAST  = CNT_W'(BIT_CLKS - 1);

  logic             sync1_q, sync1_d;
  logic             sync2_q, sync2_d;
  rx_state_e        state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [2:0]       bit_idx_q, bit_idx_d;
  logic [7:0]       shift_q, shift_d;
  logic             stop_done_c;
  logic             rx_s;

  assign rx_s = sync2_q;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      sync1_q   <= 1'b1;
      sync2_q   <= 1'b1;
      state_q   <= IDLE;
      cnt_q     <= '0;
      bit_idx_q <= '0;
      shift_q   <= '0;
    end else begin
      sync1_q   <= sync1_d;
      sync2_q   <= sync2_d;
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      bit_idx_q <= bit_idx_d;
      shift_q   <= shift_d;
    end
  end

  always_comb begin
    sync1_d     = rx;
    sync2_d     = sync1_q;
    state_d     = state_q;
    cnt_d       = cnt_q + CNT_W'(1);
    bit_idx_d   = bit_idx_q;
    shift_d     = shift_q;
    stop_done_c = 1'b0;

    case (state_q)
      IDLE: begin
        cnt_d = '0;
        if (!rx_s) state_d = START;
      end
      // Mid-start-bit check rejects short low glitches.
      START: begin
        if (cnt_q == HALF_LAST) begin
          cnt_d     = '0;
          bit_idx_d = '0;
          state_d   = rx_s ? IDLE : DATA;
        end
      end
      DATA: begin
        if (cnt_q == BIT_LAST) begin
          cnt_d              = '0;
          shift_d[bit_idx_q] = rx_s;
          bit_idx_d          = bit_idx_q + 3'd1;
          if (bit_idx_q == 3'd7) state_d = STOP;
        end
      end
      STOP: begin
        if (cnt_q == BIT_LAST) begin
          cnt_d       = '0;
          state_d     = IDLE;
          stop_done_c = 1'b1;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  assign byte_out = shift_q;
  assign byte_ok  = stop_done_c & rx_s;
  assign stop_err = stop_done_c & ~rx_s;
  assign idle_c   = (state_q == IDLE);

endmodule

// File: rtl/uart_rx_64.sv
// Assembles eight received bytes (MSB first) into a 64-bit word with valid/error
// strobes; a partial word is dropped after a long idle gap.
module uart_rx_64 #(
  parameter int unsigned CLK_FREQ     = uart_defs::CLK_FREQ,
  parameter int unsigned BAUD         = uart_defs::BAUD,
  parameter int unsigned TIMEOUT_BITS = uart_defs::TIMEOUT_BITS
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        rx,
  output logic [63:0] data_out_64,
  output logic        word_valid,
  output logic        frame_err
);

  localparam int unsigned BIT_CLKS    = CLK_FREQ / BAUD;
  localparam int unsigned TIMEOUT_CYC = TIMEOUT_BITS * BIT_CLKS;
  localparam int unsigned IDLE_W      = $clog2(TIMEOUT_CYC);
  localparam logic [IDLE_W-1:0] TIMEOUT_LAST = IDLE_W'(TIMEOUT_CYC - 1);

  logic [7:0]        byte_out;
  logic              byte_ok;
  logic              stop_err;
  logic              idle_c;

  logic [55:0]       word_sr_q, word_sr_d;
  logic [2:0]        byte_cnt_q, byte_cnt_d;
  logic [IDLE_W-1:0] idle_cnt_q, idle_cnt_d;
  logic [63:0]       data_out_q, data_out_d;
  logic              word_valid_q, word_valid_d;
  logic              frame_err_q, frame_err_d;

  uart_rx_byte #(
    .BIT_CLKS (BIT_CLKS)
  ) u_byte (
    .clk      (clk),
    .rst_n    (rst_n),
    .rx       (rx),
    .byte_out (byte_out),
    .byte_ok  (byte_ok),
    .stop_err (stop_err),
    .idle_c   (idle_c)
  );

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      word_sr_q    <= '0;
      byte_cnt_q   <= '0;
      idle_cnt_q   <= '0;
      data_out_q   <= '0;
      word_valid_q <= 1'b0;
      frame_err_q  <= 1'b0;
    end else begin
      word_sr_q    <= word_sr_d;
      byte_cnt_q   <= byte_cnt_d;
      idle_cnt_q   <= idle_cnt_d;
      data_out_q   <= data_out_d;
      word_valid_q <= word_valid_d;
      frame_err_q  <= frame_err_d;
    end
  end

  always_comb begin
    word_sr_d    = word_sr_q;
    byte_cnt_d   = byte_cnt_q;
    idle_cnt_d   = '0;
    data_out_d   = data_out_q;
    word_valid_d = 1'b0;
    frame_err_d  = 1'b0;

    if (byte_ok) begin
      word_sr_d  = {word_sr_q[47:0], byte_out};
      byte_cnt_d = byte_cnt_q + 3'd1;
      if (byte_cnt_q == 3'd7) begin
        data_out_d   = {word_sr_q, byte_out};
        word_valid_d = 1'b1;
      end
    end else if (stop_err) begin
      byte_cnt_d  = '0;
      frame_err_d = 1'b1;
    end else if (idle_c && (byte_cnt_q != 3'd0)) begin
      // Idle counter only runs with a partial word pending.
      if (idle_cnt_q == TIMEOUT_LAST) begin
        byte_cnt_d = '0;
      end else begin
        idle_cnt_d = idle_cnt_q + IDLE_W'(1);
      end
    end
  end

  assign data_out_64 = data_out_q;
  assign word_valid  = word_valid_q;
  assign frame_err   = frame_err_q;

endmodule

// File: tb/tb_uart_rx_64.sv
// Directed bench for uart_rx_64 at a scaled clock ratio of 16 clocks per bit.
`timescale 1ns/1ps
module tb_uart_rx_64;

  localparam int unsigned CLK_FREQ     = 1_843_200;
  localparam int unsigned BAUD         = 115_200;
  localparam int unsigned TIMEOUT_BITS = 20;
  localparam int          CLK_NS       = 20;
  localparam int          BIT_CLKS     = 16;
  localparam int          BIT_NS       = BIT_CLKS * CLK_NS;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        rx = 1'b1;
  logic [63:0] data_out_64;
  logic        word_valid;
  logic        frame_err;

  always #(CLK_NS / 2) clk = ~clk;

  uart_rx_64 #(
    .CLK_FREQ     (CLK_FREQ),
    .BAUD         (BAUD),
    .TIMEOUT_BITS (TIMEOUT_BITS)
  ) dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .rx          (rx),
    .data_out_64 (data_out_64),
    .word_valid  (word_valid),
    .frame_err   (frame_err)
  );

  int          errors = 0;
  int          checks = 0;
  int          n_valid = 0, n_ferr = 0, n_both = 0, n_wide = 0, n_spur = 0;
  longint      cyc = 0;
  logic        prev_wv = 1'b0;
  logic [63:0] prev_data = '0;
  logic [63:0] words_q[$];
  longint      valid_cyc[$];

  always @(posedge clk) cyc <= cyc + 1;

  // Output monitor: capture words and flag protocol violations.
  always @(negedge clk) begin
    prev_wv   <= word_valid;
    prev_data <= data_out_64;
    if (word_valid) begin
      n_valid <= n_valid + 1;
      words_q.push_back(data_out_64);
      valid_cyc.push_back(cyc);
    end
    if (frame_err) n_ferr <= n_ferr + 1;
    if (word_valid && frame_err) n_both <= n_both + 1;
    if (word_valid && prev_wv) n_wide <= n_wide + 1;
    if (rst_n && !word_valid && (data_out_64 !== prev_data)) n_spur <= n_spur + 1;
  end

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic send_byte(input logic [7:0] b, input logic stop_bit, input int bit_ns);
    rx = 1'b0;
    #(bit_ns);
    for (int i = 0; i < 8; i++) begin
      rx = b[i];
      #(bit_ns);
    end
    rx = stop_bit;
    #(bit_ns);
  endtask

  task automatic send_word(input logic [63:0] w, input int bit_ns);
    for (int i = 7; i >= 0; i--) send_byte(w[8*i +: 8], 1'b1, bit_ns);
  endtask

  task automatic idle_bits(input int n);
    rx = 1'b1;
    #(n * BIT_NS);
    @(negedge clk);
  endtask

  function automatic logic [63:0] last_word();
    if (words_q.size() == 0) return 64'hx;
    return words_q[words_q.size() - 1];
  endfunction

  typedef struct {
    string       name;
    logic [63:0] word;
    int          bit_ns;
    logic [63:0] exp_word;
  } vec_t;

  vec_t vecs[6];

  initial begin
    int v0, f0;
    logic [63:0] held;
    longint gap;

    vecs[0] = '{"single_81A3", 64'h81A34D6FF6B2C581, BIT_NS,     64'h81A34D6FF6B2C581};
    vecs[1] = '{"single_4423", 64'h44233E79479427F7, BIT_NS,     64'h44233E79479427F7};
    vecs[2] = '{"all_zero",    64'h0000000000000000, BIT_NS,     64'h0000000000000000};
    vecs[3] = '{"all_ones",    64'hFFFFFFFFFFFFFFFF, BIT_NS,     64'hFFFFFFFFFFFFFFFF};
    vecs[4] = '{"fast_2pct",   64'h0123456789ABCDEF, BIT_NS - 6, 64'h0123456789ABCDEF};
    vecs[5] = '{"slow_2pct",   64'hFEDCBA9876543210, BIT_NS + 6, 64'hFEDCBA9876543210};

    // Reset state.
    repeat (3) @(negedge clk);
    check("rst_data", data_out_64, 64'h0);
    check("rst_valid", 64'(word_valid), 64'h0);
    check("rst_ferr", 64'(frame_err), 64'h0);
    rst_n = 1'b1;
    idle_bits(2);

    // Table of single words, including +/-2% bit period.
    for (int i = 0; i < 6; i++) begin
      v0 = n_valid; f0 = n_ferr;
      send_word(vecs[i].word, vecs[i].bit_ns);
      idle_bits(2);
      check({vecs[i].name, "_nvalid"}, 64'(n_valid - v0), 64'd1);
      check({vecs[i].name, "_nferr"}, 64'(n_ferr - f0), 64'd0);
      check({vecs[i].name, "_word"}, last_word(), vecs[i].exp_word);
      check({vecs[i].name, "_hold"}, data_out_64, vecs[i].exp_word);
    end

    // Two words back to back with no idle gap.
    v0 = n_valid;
    send_word(64'h81A34D6FF6B2C581, BIT_NS);
    send_word(64'h44233E79479427F7, BIT_NS);
    idle_bits(2);
    check("b2b_nvalid", 64'(n_valid - v0), 64'd2);
    check("b2b_first", words_q[words_q.size() - 2], 64'h81A34D6FF6B2C581);
    check("b2b_second", last_word(), 64'h44233E79479427F7);
    gap = valid_cyc[valid_cyc.size() - 1] - valid_cyc[valid_cyc.size() - 2];
    check("b2b_spacing_ok", 64'((gap >= 80 * BIT_CLKS - 1) && (gap <= 80 * BIT_CLKS + 1)), 64'd1);

    // Short low glitch, then a good word.
    v0 = n_valid; f0 = n_ferr;
    rx = 1'b0;
    #(4 * CLK_NS);
    rx = 1'b1;
    idle_bits(2);
    check("glitch_nvalid", 64'(n_valid - v0), 64'd0);
    check("glitch_nferr", 64'(n_ferr - f0), 64'd0);
    send_word(64'hC3A55A3C0F1E2D4B, BIT_NS);
    idle_bits(2);
    check("glitch_after", last_word(), 64'hC3A55A3C0F1E2D4B);

    // Bad stop bit.
    v0 = n_valid; f0 = n_ferr;
    send_byte(8'h11, 1'b0, BIT_NS);
    idle_bits(2);
    check("badstop_nferr", 64'(n_ferr - f0), 64'd1);
    check("badstop_nvalid", 64'(n_valid - v0), 64'd0);
    check("badstop_hold", data_out_64, 64'hC3A55A3C0F1E2D4B);
    send_word(64'h0102030405060708, BIT_NS);
    idle_bits(2);
    check("badstop_after", last_word(), 64'h0102030405060708);

    // Partial word dropped after a long idle gap.
    v0 = n_valid;
    send_byte(8'hAA, 1'b1, BIT_NS);
    send_byte(8'hBB, 1'b1, BIT_NS);
    send_byte(8'hCC, 1'b1, BIT_NS);
    idle_bits(21);
    send_word(64'h1122334455667788, BIT_NS);
    idle_bits(2);
    check("timeout_nvalid", 64'(n_valid - v0), 64'd1);
    check("timeout_word", last_word(), 64'h1122334455667788);

    // A short gap mid-word must not drop the partial word.
    v0 = n_valid;
    send_byte(8'hDE, 1'b1, BIT_NS);
    send_byte(8'hAD, 1'b1, BIT_NS);
    send_byte(8'hBE, 1'b1, BIT_NS);
    send_byte(8'hEF, 1'b1, BIT_NS);
    idle_bits(5);
    send_byte(8'h01, 1'b1, BIT_NS);
    send_byte(8'h23, 1'b1, BIT_NS);
    send_byte(8'h45, 1'b1, BIT_NS);
    send_byte(8'h67, 1'b1, BIT_NS);
    idle_bits(2);
    check("shortgap_nvalid", 64'(n_valid - v0), 64'd1);
    check("shortgap_word", last_word(), 64'hDEADBEEF01234567);

    // Reset mid-word with the line idle.
    send_byte(8'h99, 1'b1, BIT_NS);
    send_byte(8'h88, 1'b1, BIT_NS);
    send_byte(8'h77, 1'b1, BIT_NS);
    send_byte(8'h66, 1'b1, BIT_NS);
    idle_bits(1);
    held = data_out_64;
    check("prereset_hold", held, 64'hDEADBEEF01234567);
    rst_n = 1'b0;
    repeat (3) @(negedge clk);
    check("midrst_data", data_out_64, 64'h0);
    check("midrst_valid", 64'(word_valid), 64'h0);
    check("midrst_ferr", 64'(frame_err), 64'h0);
    rst_n = 1'b1;
    idle_bits(1);
    v0 = n_valid;
    send_word(64'h0A0B0C0D0E0F1011, BIT_NS);
    idle_bits(2);
    check("postrst_nvalid", 64'(n_valid - v0), 64'd1);
    check("postrst_word", last_word(), 64'h0A0B0C0D0E0F1011);

    // Global protocol properties seen by the monitor.
    check("valid_and_ferr", 64'(n_both), 64'd0);
    check("valid_width", 64'(n_wide), 64'd0);
    check("data_changes_only_on_valid", 64'(n_spur), 64'd0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
